// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// Holds the miss FSM state encoding, RV32 load/store width codes and geometry helpers.
package dcache_pkg;

    typedef enum logic [1:0] {
        S_LOOKUP    = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic int calc_off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int calc_idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int calc_tag_w(input int num_sets, input int words_per_line);
        return 30 - calc_off_w(words_per_line) - calc_idx_w(num_sets);
    endfunction

endpackage

// File: rtl/dcache_wb_ls_align.sv
// Combinational byte-lane logic: load extraction with sign/zero extension, or store merge.
// STORE selects which result drives the output; zero latency, no flow control.
module ls_align
    import dcache_pkg::*;
#(
    parameter logic STORE = 1'b0
) (
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] loaded;
    logic [31:0] merged;

    always_comb begin
        lane_b = word[{byte_off, 3'b000} +: 8];
        lane_h = word[{byte_off[1], 4'b0000} +: 16];

        case (funct3)
            F3_LB:   loaded = {{24{lane_b[7]}}, lane_b};
            F3_LH:   loaded = {{16{lane_h[15]}}, lane_h};
            F3_LW:   loaded = word;
            F3_LBU:  loaded = {24'h0, lane_b};
            F3_LHU:  loaded = {16'h0, lane_h};
            default: loaded = 32'h0;
        endcase

        merged = word;
        case (funct3[1:0])
            F3_SB[1:0]: merged[{byte_off, 3'b000} +: 8]     = wdata[7:0];
            F3_SH[1:0]: merged[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
            F3_SW[1:0]: merged = wdata;
            default:    ;
        endcase

        result = STORE ? merged : loaded;
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate D-cache; load hit data one cycle after the request.
// stall holds the pipeline while a dirty victim is written back and the line is refilled.
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int NUM_SETS       = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          MemRead,
    input  logic                          MemWrite,
    input  logic [31:0]                   addr,
    input  logic [31:0]                   WriteData,
    input  logic [2:0]                    funct3,
    output logic [31:0]                   output_data,
    output logic                          stall,
    output logic                          misalign,
    output logic                          mem_req_valid,
    output logic                          mem_req_we,
    output logic [31:0]                   mem_req_addr,
    output logic [32*WORDS_PER_LINE-1:0]  mem_req_wdata,
    input  logic                          mem_req_ready,
    input  logic                          mem_resp_valid,
    input  logic [32*WORDS_PER_LINE-1:0]  mem_resp_rdata,
    output logic [31:0]                   hit_count,
    output logic [31:0]                   miss_count
);

    localparam int LINE_W = 32 * WORDS_PER_LINE;
    localparam int OFF_W  = calc_off_w(WORDS_PER_LINE);
    localparam int IDX_W  = calc_idx_w(NUM_SETS);
    localparam int TAG_W  = calc_tag_w(NUM_SETS, WORDS_PER_LINE);

    state_t             state, state_nxt;
    logic               req_done;
    logic               replay;
    logic [TAG_W-1:0]   tag_arr [NUM_SETS];
    logic [NUM_SETS-1:0] valid_arr, dirty_arr;
    logic [LINE_W-1:0]  data_arr [NUM_SETS];
    logic [31:0]        rd_word;
    logic [1:0]         rd_off;
    logic [2:0]         rd_f3;

    logic [OFF_W-1:0]   word_sel;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               req, aligned, hit, lookup, access, commit;
    logic [LINE_W-1:0]  cur_line;
    logic [31:0]        cur_word, store_word;

    assign word_sel = addr[OFF_W+1:2];
    assign idx      = addr[OFF_W+2 +: IDX_W];
    assign tag      = addr[31 -: TAG_W];
    assign req      = MemRead | MemWrite;

    always_comb begin
        aligned = 1'b1;
        case (funct3[1:0])
            2'b01:   aligned = !addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign cur_line = data_arr[idx];
    assign cur_word = cur_line[{word_sel, 5'b00000} +: 32];
    assign hit      = valid_arr[idx] && (tag_arr[idx] == tag);
    assign lookup   = (state == S_LOOKUP);
    assign access   = req && aligned;
    assign commit   = lookup && access && hit;
    assign stall    = access && (!lookup || !hit);

    ls_align #(.STORE(1'b0)) u_load (
        .word     (rd_word),
        .byte_off (rd_off),
        .funct3   (rd_f3),
        .wdata    (32'h0),
        .result   (output_data)
    );

    ls_align #(.STORE(1'b1)) u_store (
        .word     (cur_word),
        .byte_off (addr[1:0]),
        .funct3   (funct3),
        .wdata    (WriteData),
        .result   (store_word)
    );

    always_comb begin
        state_nxt     = state;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = {tag, idx, {(OFF_W+2){1'b0}}};
        mem_req_wdata = cur_line;
        case (state)
            S_LOOKUP: begin
                if (access && !hit)
                    state_nxt = (valid_arr[idx] && dirty_arr[idx]) ? S_WRITEBACK : S_REFILL;
            end
            S_WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {tag_arr[idx], idx, {(OFF_W+2){1'b0}}};
                if (mem_req_ready)
                    state_nxt = S_REFILL;
            end
            S_REFILL: begin
                // Request is dropped once accepted; the response follows later.
                mem_req_valid = !req_done;
                if (mem_resp_valid)
                    state_nxt = S_LOOKUP;
            end
            default: state_nxt = S_LOOKUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LOOKUP;
            req_done   <= 1'b0;
            replay     <= 1'b0;
            valid_arr  <= '0;
            dirty_arr  <= '0;
            for (int i = 0; i < NUM_SETS; i++)
                tag_arr[i] <= '0;
            rd_word    <= 32'h0;
            rd_off     <= 2'b00;
            rd_f3      <= 3'b000;
            misalign   <= 1'b0;
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            state    <= state_nxt;
            req_done <= (state == S_REFILL) && (state_nxt == S_REFILL) && (req_done || mem_req_ready);
            replay   <= (state == S_REFILL) && (state_nxt == S_LOOKUP);
            misalign <= req && !aligned;

            if (state == S_REFILL && mem_resp_valid) begin
                tag_arr[idx]   <= tag;
                valid_arr[idx] <= 1'b1;
                dirty_arr[idx] <= 1'b0;
            end else if (commit && MemWrite) begin
                dirty_arr[idx] <= 1'b1;
            end

            // A misaligned load reads back as zero regardless of width code.
            if (commit && !MemWrite) begin
                rd_word <= cur_word;
                rd_off  <= addr[1:0];
                rd_f3   <= funct3;
            end else if (req && !aligned && !MemWrite) begin
                rd_word <= 32'h0;
            end

            if (lookup && access && !replay) begin
                if (hit) begin
                    if (hit_count != 32'hFFFF_FFFF)
                        hit_count <= hit_count + 32'd1;
                end else begin
                    if (miss_count != 32'hFFFF_FFFF)
                        miss_count <= miss_count + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_REFILL && mem_resp_valid)
            data_arr[idx] <= mem_resp_rdata;
        else if (commit && MemWrite)
            data_arr[idx][{word_sel, 5'b00000} +: 32] <= store_word;
    end

endmodule
